memory_port: RTL and testbench

MEMORY_PORT -- requirements
Module: memory_port

---
 rtl/memory_port.sv | 127 ++++++++++++
 tb/tb_memory_port.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port.sv
// Single-port word memory shared by instruction fetch and data load/store.
// One access in flight; data requests win over fetches when both wait in IDLE.
module memory_port #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  input  logic        ld,
  input  logic        st,
  input  logic [31:0] data_addr,
  input  logic [31:0] st_data,
  output logic [31:0] instruction,
  output logic [31:0] ld_data,
  output logic        wait_instr,
  output logic        wait_data,
  output logic        instr_segv,
  output logic        data_segv
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0] data_q;
  logic st_q;
  logic fault_q;
  logic accept_i, accept_d;
  logic fault_i, fault_d;
  logic last_busy;

  logic [31:0] mem [DEPTH];

  // Misaligned, beyond the store, or (data only) both ld and st.
  assign fault_i = (instr_addr[1:0] != 2'b00)
                 | (instr_addr[31:DEPTH_LOG2+2] != '0);
  assign fault_d = (data_addr[1:0] != 2'b00)
                 | (data_addr[31:DEPTH_LOG2+2] != '0)
                 | (ld & st);

  assign last_busy = (cnt == 4'd0);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept_i = 1'b0;
    accept_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld | st) begin
          accept_d = 1'b1;
          cnt_n    = LAT_M1;
          state_n  = fault_d ? RESP_D : BUSY_D;
        end else if (instr_req) begin
          accept_i = 1'b1;
          cnt_n    = LAT_M1;
          state_n  = fault_i ? RESP_I : BUSY_I;
        end
      end
      BUSY_I: begin
        if (last_busy) state_n = RESP_I;
        else           cnt_n   = cnt - 4'd1;
      end
      BUSY_D: begin
        if (last_busy) state_n = RESP_D;
        else           cnt_n   = cnt - 4'd1;
      end
      RESP_I: state_n = IDLE;
      RESP_D: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      idx_q       <= '0;
      data_q      <= 32'd0;
      st_q        <= 1'b0;
      fault_q     <= 1'b0;
      instruction <= 32'd0;
      ld_data     <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept_d) begin
        idx_q   <= data_addr[DEPTH_LOG2+1:2];
        data_q  <= st_data;
        st_q    <= st;
        fault_q <= fault_d;
      end else if (accept_i) begin
        idx_q   <= instr_addr[DEPTH_LOG2+1:2];
        st_q    <= 1'b0;
        fault_q <= fault_i;
      end
      if (state == BUSY_I && last_busy)
        instruction <= mem[idx_q];
      if (state == BUSY_D && last_busy && !st_q)
        ld_data <= mem[idx_q];
    end
  end

  // Contents survive reset; a reset on the final busy edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && state == BUSY_D && last_busy && st_q)
      mem[idx_q] <= data_q;
  end

  assign wait_instr = instr_req & (state != RESP_I);
  assign wait_data  = (ld | st) & (state != RESP_D);
  assign instr_segv = (state == RESP_I) & fault_q;
  assign data_segv  = (state == RESP_D) & fault_q;

endmodule

// File: tb/tb_memory_port.sv
// Directed bench for memory_port: timing of waits, data paths, faults, reset.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_memory_port;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        ld;
  logic        st;
  logic [31:0] data_addr;
  logic [31:0] st_data;
  logic [31:0] instruction;
  logic [31:0] ld_data;
  logic        wait_instr;
  logic        wait_data;
  logic        instr_segv;
  logic        data_segv;

  int n_run  = 0;
  int n_fail = 0;

  memory_port #(
    .DEPTH_LOG2(8),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr_req(instr_req),
    .instr_addr(instr_addr),
    .ld(ld),
    .st(st),
    .data_addr(data_addr),
    .st_data(st_data),
    .instruction(instruction),
    .ld_data(ld_data),
    .wait_instr(wait_instr),
    .wait_data(wait_data),
    .instr_segv(instr_segv),
    .data_segv(data_segv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a data request until wait_data drops; report wait cycles and RESP values.
  task automatic do_data(input logic l, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         output int nwait, output logic [31:0] rd,
                         output logic seg);
    logic done;
    ld = l;
    st = s;
    data_addr = a;
    st_data = d;
    nwait = 0;
    done = 1'b0;
    rd = 32'd0;
    seg = 1'b0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!wait_data) begin
        done = 1'b1;
        rd = ld_data;
        seg = data_segv;
      end else begin
        nwait++;
        tick();
        #1;
      end
    end
    chk("data_done", {31'd0, done}, 32'd1);
    tick();
    ld = 1'b0;
    st = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, output int nwait,
                          output logic [31:0] ins, output logic seg);
    logic done;
    instr_req = 1'b1;
    instr_addr = a;
    nwait = 0;
    done = 1'b0;
    ins = 32'd0;
    seg = 1'b0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!wait_instr) begin
        done = 1'b1;
        ins = instruction;
        seg = instr_segv;
      end else begin
        nwait++;
        tick();
        #1;
      end
    end
    chk("fetch_done", {31'd0, done}, 32'd1);
    tick();
    instr_req = 1'b0;
  endtask

  int nw;
  int dcyc;
  int icyc;
  logic [31:0] rd;
  logic sg;

  initial begin
    reset = 1'b1;
    instr_req = 1'b0;
    instr_addr = 32'd0;
    ld = 1'b0;
    st = 1'b0;
    data_addr = 32'd0;
    st_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_instr", instruction, 32'd0);
    chk("rst_ld", ld_data, 32'd0);
    chk("rst_waits", {30'd0, wait_instr, wait_data}, 32'd0);
    chk("rst_segv", {30'd0, instr_segv, data_segv}, 32'd0);
    tick();

    // Store then load at 0x10
    do_data(1'b0, 1'b1, 32'h10, 32'h80801234, nw, rd, sg);
    chk("st10_wait", nw, LAT + 1);
    chk("st10_seg", {31'd0, sg}, 32'd0);
    chk("st10_ld_keep", rd, 32'd0);
    do_data(1'b1, 1'b0, 32'h10, 32'h0, nw, rd, sg);
    chk("ld10_wait", nw, LAT + 1);
    chk("ld10_data", rd, 32'h80801234);

    // Store at 0x20, then fetch it
    do_data(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, nw, rd, sg);
    do_data(1'b0, 1'b1, 32'h0, 32'h00000055, nw, rd, sg);
    do_fetch(32'h20, nw, rd, sg);
    chk("f20_wait", nw, LAT + 1);
    chk("f20_instr", rd, 32'hDEADBEEF);
    chk("f20_seg", {31'd0, sg}, 32'd0);

    // Faults: misaligned, out of range, ld+st
    do_data(1'b0, 1'b1, 32'h11, 32'h11111111, nw, rd, sg);
    chk("st11_wait", nw, 1);
    chk("st11_seg", {31'd0, sg}, 32'd1);
    chk("st11_ld_keep", rd, 32'h80801234);
    #1;
    chk("st11_seg_1cyc", {31'd0, data_segv}, 32'd0);
    do_data(1'b0, 1'b1, 32'h400, 32'h22222222, nw, rd, sg);
    chk("st400_wait", nw, 1);
    chk("st400_seg", {31'd0, sg}, 32'd1);
    do_data(1'b1, 1'b1, 32'h10, 32'h33333333, nw, rd, sg);
    chk("ldst_wait", nw, 1);
    chk("ldst_seg", {31'd0, sg}, 32'd1);
    do_data(1'b1, 1'b0, 32'h10, 32'h0, nw, rd, sg);
    chk("ld10_unch", rd, 32'h80801234);
    do_data(1'b1, 1'b0, 32'h0, 32'h0, nw, rd, sg);
    chk("ld0_unch", rd, 32'h00000055);

    // Load and fetch raised together: data first, fetch follows
    ld = 1'b1;
    data_addr = 32'h10;
    instr_req = 1'b1;
    instr_addr = 32'h20;
    dcyc = 0;
    icyc = 0;
    #1;
    for (int c = 1; c <= 30; c++) begin
      if (ld && !wait_data) begin
        dcyc = c;
        chk("pri_ld", ld_data, 32'h80801234);
      end
      if (instr_req && !wait_instr) begin
        icyc = c;
        chk("pri_instr", instruction, 32'hDEADBEEF);
      end
      tick();
      if (dcyc == c) ld = 1'b0;
      if (icyc == c) instr_req = 1'b0;
      #1;
      if (icyc != 0) break;
    end
    ld = 1'b0;
    instr_req = 1'b0;
    chk("pri_dcyc", dcyc, LAT + 2);
    chk("pri_icyc", icyc, 2 * LAT + 4);
    tick();

    // Reset on the last busy cycle of a store aborts the write
    do_data(1'b0, 1'b1, 32'h30, 32'hCAFE0001, nw, rd, sg);
    st = 1'b1;
    data_addr = 32'h30;
    st_data = 32'h00000001;
    tick();
    tick();
    reset = 1'b1;
    st = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_ld", ld_data, 32'd0);
    chk("rst2_instr", instruction, 32'd0);
    chk("rst2_segv", {30'd0, instr_segv, data_segv}, 32'd0);
    tick();
    do_fetch(32'h20, nw, rd, sg);
    chk("rst2_f20", rd, 32'hDEADBEEF);
    do_data(1'b1, 1'b0, 32'h30, 32'h0, nw, rd, sg);
    chk("ld30_kept", rd, 32'hCAFE0001);

    // Misaligned fetch keeps the previous instruction
    do_fetch(32'h3, nw, rd, sg);
    chk("f3_wait", nw, 1);
    chk("f3_seg", {31'd0, sg}, 32'd1);
    chk("f3_instr_keep", rd, 32'hDEADBEEF);
    do_fetch(32'h400, nw, rd, sg);
    chk("f400_seg", {31'd0, sg}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
